// File: rtl/cla_multicycle_adder.sv
// Sequential adder: one SLICE-bit carry-lookahead stage per clock, carry registered between slices.
// Optional signed overflow output is enabled by defining CLA_SIGNED_OVF_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// in_ready is high only in IDLE, out_valid only in DONE, and neither side may retract early.
module cla_multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [IDXW-1:0]  idx;

  int               base;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] ssum;
  logic [SLICE:0]   c;

  assign in_ready = (state == IDLE);

  // Each carry is expanded into its full generate/propagate sum-of-products from the slice carry-in.
  always_comb begin : lookahead
    logic cc;
    logic pp;
    base = int'(idx) * SLICE;
    sa   = a_r[base +: SLICE];
    sb   = b_r[base +: SLICE];
    g    = sa & sb;
    p    = sa ^ sb;
    c    = '0;
    c[0] = carry;
    for (int i = 0; i < SLICE; i++) begin
      cc = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = cc | (pp & carry);
    end
    ssum = p ^ c[SLICE-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef CLA_SIGNED_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[base +: SLICE] <= ssum;
          carry              <= c[SLICE];
          if (idx == IDXW'(NSLICE - 1)) begin
            cout      <= c[SLICE];
`ifdef CLA_SIGNED_OVF_EN
            ovf       <= c[SLICE] ^ c[SLICE-1];
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_multicycle_adder.sv
// Directed and random checks of cla_multicycle_adder: a 16/4 instance and a 16/16 single-slice instance.
module tb_cla_multicycle_adder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [15:0] a, b, sum;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1;
  logic [15:0] a1, b1, sum1;
`ifdef CLA_SIGNED_OVF_EN
  logic        ovf, ovf1;
`endif

  int checks   = 0;
  int failures = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  cla_multicycle_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef CLA_SIGNED_OVF_EN
    , .ovf(ovf)
`endif
  );

  cla_multicycle_adder #(.WIDTH(16), .SLICE(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
`ifdef CLA_SIGNED_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid with a cycle budget; returns edges counted since the acceptance edge.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // Presents one operand triple, checks latency and result, stalls, then completes the handshake.
  task automatic run_op(input logic [15:0] a_v, input logic [15:0] b_v, input logic c_v,
                        input int stall, input string tag);
    logic [16:0] e;
    logic [15:0] held;
    int          lat;
    exp_q.push_back({1'b0, a_v} + {1'b0, b_v} + {16'b0, c_v});
    a = a_v; b = b_v; cin = c_v; in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    a = 16'(~a_v); b = 16'($urandom); cin = ~c_v;
    wait_result(lat);
    check({tag, "_latency"}, lat, 4);
    e = exp_q.pop_front();
    check({tag, "_sum"}, sum, e[15:0]);
    check({tag, "_cout"}, cout, e[16]);
`ifdef CLA_SIGNED_OVF_EN
    check({tag, "_ovf"}, ovf, (a_v[15] == b_v[15]) && (e[15] != a_v[15]));
`endif
    held = sum;
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, "_stall_hold"}, {out_valid, in_ready, sum}, {1'b1, 1'b0, held});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_released"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin : stimulus
    int          lat;
    logic [15:0] held;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("reset_state", {out_valid, in_ready, cout, sum}, {1'b0, 1'b1, 1'b0, 16'h0000});

    // Basic, full carry ripple.
    run_op(16'h0001, 16'h0000, 1'b0, 0, "basic");
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, "ripple");
    run_op(16'h8000, 16'h8000, 1'b0, 1, "neg_ovf");

    // Backpressure with a second operand offered during the stall.
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h1234; b = 16'h1111; cin = 1'b1;
    wait_result(lat);
    check("bp_latency", lat, 4);
    check("bp_result", {cout, sum}, {1'b0, 16'h8000});
`ifdef CLA_SIGNED_OVF_EN
    check("bp_ovf", ovf, 1);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", {out_valid, in_ready, cout, sum}, {1'b1, 1'b0, 1'b0, 16'h8000});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release", {out_valid, in_ready}, 2'b01);
    step();
    in_valid = 1'b0;
    wait_result(lat);
    check("bp_second_latency", lat, 4);
    check("bp_second_result", {cout, sum}, {1'b0, 16'h2346});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-operation: no result may ever appear for the aborted operand.
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("reset_mid_run", {out_valid, in_ready, cout, sum}, {1'b0, 1'b1, 1'b0, 16'h0000});
    for (int i = 0; i < 6; i++) begin
      step();
      check("reset_no_result", out_valid, 0);
    end

    // Single-slice instance: latency of one edge.
    a1 = 16'hB000; b1 = 16'h6000; cin1 = 1'b0; in_valid1 = 1'b1;
    check("single_in_ready", in_ready1, 1);
    step();
    in_valid1 = 1'b0;
    check("single_pending", out_valid1, 0);
    step();
    check("single_result", {out_valid1, cout1, sum1}, {1'b1, 1'b1, 16'h1000});
`ifdef CLA_SIGNED_OVF_EN
    check("single_ovf", ovf1, 0);
`endif
    held = sum1;
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    check("single_release", {out_valid1, in_ready1}, 2'b01);

    for (int n = 0; n < 1000; n++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2), "random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
